// File: rtl/npc_if.sv
// ============================================================================
// Module      : npc_if
// Description : Decode-side bundle for the next-PC generator. The decoder/
//               datapath (master) supplies the control selects, current PC,
//               immediate field and JR source. It receives the next fetch
//               address and the registered link address back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface npc_if;
   logic        zero;    // ALU equality flag (rs == rt)
   logic        ifbeq;   // current instruction is BEQ
   logic        j;       // current instruction is J
   logic        jal;     // current instruction is JAL
   logic        jr;      // current instruction is JR
   logic [31:0] pc;      // current fetch address
   logic [25:0] imm26;   // instr[25:0]; [15:0] is the branch offset
   logic [31:0] rd1;     // GPR[rs], JR target
   logic [31:0] spc;     // registered link address
   logic [31:0] npc;     // next fetch address

   modport master (
      output zero, ifbeq, j, jal, jr, pc, imm26, rd1,
      input  spc, npc
   );

   modport slave (
      input  zero, ifbeq, j, jal, jr, pc, imm26, rd1,
      output spc, npc
   );
endinterface

`default_nettype wire

// File: rtl/npc_unit.sv
// ============================================================================
// Module      : npc_unit
// Description : MIPS-style next-PC generator. Selects the next fetch address
//               combinationally (JR > J/JAL > taken BEQ > PC+4) and keeps a
//               registered link address captured on JAL for write-back to $ra.
//               Optional macro NPC_DELAY_SLOT_EN: branch-delay-slot link
//               (link = pc + 8); jump/branch targets stay relative to pc + 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_unit #(
   parameter logic [31:0] RESET_SPC = 32'h0000_0000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   npc_if.slave      bus
);

   logic [31:0] seq_w;
   logic [31:0] boff_w;
   logic [31:0] btgt_w;
   logic [31:0] jtgt_w;
   logic [31:0] link_w;
   logic [31:0] npc_w;
   logic [31:0] spc_d;
   logic [31:0] spc_q;

   // Candidate targets; all arithmetic wraps modulo 2^32.
   assign seq_w  = bus.pc + 32'd4;
   assign boff_w = {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
   assign btgt_w = seq_w + boff_w;
   assign jtgt_w = {seq_w[31:28], bus.imm26, 2'b00};

`ifdef NPC_DELAY_SLOT_EN
   // With a delay slot the return skips the slot instruction.
   assign link_w = bus.pc + 32'd8;
`else
   assign link_w = seq_w;
`endif

   // Priority select of the next fetch address; illegal multi-selects resolve by priority.
   always_comb begin
      npc_w = seq_w;
      if (bus.jr) begin
         npc_w = bus.rd1;
      end else if (bus.jal || bus.j) begin
         npc_w = jtgt_w;
      end else if (bus.ifbeq && bus.zero) begin
         npc_w = btgt_w;
      end
   end

   // Link capture only on JAL, otherwise hold.
   always_comb begin
      spc_d = spc_q;
      if (bus.jal) begin
         spc_d = link_w;
      end
   end

   // Link register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spc_q <= RESET_SPC;
      end else begin
         spc_q <= spc_d;
      end
   end

   assign bus.npc = npc_w;
   assign bus.spc = spc_q;

endmodule

`default_nettype wire

// File: tb/tb_npc_unit.sv
// ============================================================================
// Module      : tb_npc_unit
// Description : Self-checking bench for npc_unit: directed vector table,
//               hand-written reset/link sequences, and randomized stimulus
//               against a behavioural next-PC / link model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_npc_unit;

`ifdef NPC_DELAY_SLOT_EN
   localparam logic [31:0] LINK_OFF = 32'd8;
`else
   localparam logic [31:0] LINK_OFF = 32'd4;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   npc_if u_if ();

   npc_unit #(.RESET_SPC(32'h0000_0000)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [25:0] imm26;
      logic        zero;
      logic        ifbeq;
      logic        j;
      logic        jal;
      logic        jr;
      logic [31:0] rd1;
      logic [31:0] exp_npc;
   } vec_t;

   vec_t vecs [0:8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [25:0] imm26, input logic zero,
                        input logic ifbeq, input logic j, input logic jal, input logic jr,
                        input logic [31:0] rd1);
      u_if.pc    = pc;
      u_if.imm26 = imm26;
      u_if.zero  = zero;
      u_if.ifbeq = ifbeq;
      u_if.j     = j;
      u_if.jal   = jal;
      u_if.jr    = jr;
      u_if.rd1   = rd1;
   endtask

   // Behavioural next-PC: plain integer arithmetic from the instruction-set rules.
   function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [25:0] imm26,
                                             input logic zero, input logic ifbeq, input logic j,
                                             input logic jal, input logic jr, input logic [31:0] rd1);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      off = int'($signed(imm26[15:0])) * 4;
      if (jr)               return rd1;
      if (j || jal)         return (seq & 32'hF000_0000) | (32'(imm26) * 32'd4);
      if (ifbeq && zero)    return seq + 32'(off);
      return seq;
   endfunction

   logic [31:0] exp_spc;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      vecs[0] = '{"beq_taken",   32'h0000_0000, 26'b00001000100000000000000001, 1, 1, 0, 0, 0, 32'h0, 32'h0000_0008};
      vecs[1] = '{"beq_not",     32'h0000_0000, 26'b00001000100000000000000001, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0004};
      vecs[2] = '{"beq_back",    32'h0000_3010, 26'h000FFFE,                    1, 1, 0, 0, 0, 32'h0, 32'h0000_300C};
      vecs[3] = '{"j_abs",       32'h0000_3000, 26'h0000C05,                    0, 0, 1, 0, 0, 32'h0, 32'h0000_3014};
      vecs[4] = '{"jr_wins",     32'h0000_3000, 26'h0000C05,                    0, 0, 1, 0, 1, 32'h0000_4000, 32'h0000_4000};
      vecs[5] = '{"seq_wrap",    32'hFFFF_FFFC, 26'h3FFFFFF,                    0, 0, 0, 0, 0, 32'h0, 32'h0000_0000};
      vecs[6] = '{"jal_region",  32'h8FFF_FFFC, 26'h0000001,                    1, 1, 0, 1, 0, 32'h0, 32'h9000_0004};
      vecs[7] = '{"zero_nobeq",  32'h0000_1000, 26'h0000010,                    1, 0, 0, 0, 0, 32'h0, 32'h0000_1004};
      vecs[8] = '{"jr_unalign",  32'h0000_1000, 26'h0,                          1, 1, 1, 1, 1, 32'h1234_5677, 32'h1234_5677};

      // Reset state.
      #2;
      chk("reset_spc", u_if.spc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table (jal vectors also feed the link model).
      exp_spc = 32'h0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         drive(vecs[i].pc, vecs[i].imm26, vecs[i].zero, vecs[i].ifbeq, vecs[i].j,
               vecs[i].jal, vecs[i].jr, vecs[i].rd1);
         #1;
         chk(vecs[i].name, u_if.npc, vecs[i].exp_npc);
         if (vecs[i].jal) exp_spc = vecs[i].pc + LINK_OFF;
         @(posedge clk);
         #1;
         chk({vecs[i].name, "_spc"}, u_if.spc, exp_spc);
      end

      // JAL capture at pc=0x3008.
      @(negedge clk);
      drive(32'h0000_3008, 26'h0000C00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      chk("jal_npc", u_if.npc, 32'h0000_3000);
      @(posedge clk);
      #1;
      chk("jal_spc", u_if.spc, 32'h0000_3008 + LINK_OFF);

      // Hold across several edges with pc changing.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(32'h0000_5000 + 32'(k * 4), 26'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         @(posedge clk);
         #1;
         chk("spc_hold", u_if.spc, 32'h0000_3008 + LINK_OFF);
      end

      // Asynchronous reset mid-cycle, no clock edge involved.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", u_if.spc, 32'h0);
      // JAL while reset is held must not capture.
      drive(32'h0000_3008, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_blocks_jal", u_if.spc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h0000_3008, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk("post_rst_hold", u_if.spc, 32'h0);
      @(negedge clk);
      drive(32'h0000_3008, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk("post_rst_jal", u_if.spc, 32'h0000_3008 + LINK_OFF);
      exp_spc = 32'h0000_3008 + LINK_OFF;

      // Randomized stimulus against the behavioural model.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] r_pc;
         logic [25:0] r_imm;
         logic [31:0] r_rd1;
         logic        r_z, r_b, r_j, r_jal, r_jr;
         @(negedge clk);
         r_pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
         r_imm = 26'($urandom);
         r_rd1 = $urandom;
         r_z   = 1'($urandom);
         r_b   = ($urandom_range(0, 2) == 0);
         r_j   = ($urandom_range(0, 4) == 0);
         r_jal = ($urandom_range(0, 4) == 0);
         r_jr  = ($urandom_range(0, 5) == 0);
         drive(r_pc, r_imm, r_z, r_b, r_j, r_jal, r_jr, r_rd1);
         #1;
         chk("rand_npc", u_if.npc, model_npc(r_pc, r_imm, r_z, r_b, r_j, r_jal, r_jr, r_rd1));
         if (r_jal) exp_spc = r_pc + LINK_OFF;
         @(posedge clk);
         #1;
         chk("rand_spc", u_if.spc, exp_spc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
